// File: rtl/sha256_pkg.sv
// Shared constants and state encoding for the SHA-256 stream padder.
package sha256_pkg;

    localparam int         SHA256_BLK_W = 512;
    localparam int         SHA256_LEN_W = 64;
    localparam logic [7:0] PAD_BYTE     = 8'h80;

    typedef enum logic [1:0] {
        ACCUM,
        SEND,
        PAD2
    } pad_state_e;

endpackage

// File: rtl/sha256_pad_fill.sv
// Combinational block builder: keeps bytes below pos_i, optional 0x80 at
// pos_i, zeros elsewhere, optional big-endian length in the last 8 bytes.
module sha256_pad_fill
    import sha256_pkg::*;
(
    input  logic [SHA256_BLK_W-1:0] data_i,
    input  logic [6:0]              pos_i,
    input  logic [SHA256_LEN_W-1:0] len_i,
    input  logic                    put80_i,
    input  logic                    putlen_i,
    output logic [SHA256_BLK_W-1:0] blk_o
);

    always_comb begin
        blk_o = '0;
        for (int k = 0; k < 64; k++) begin
            if (7'(k) < pos_i) begin
                blk_o[511-8*k -: 8] = data_i[511-8*k -: 8];
            end else if (7'(k) == pos_i && put80_i) begin
                blk_o[511-8*k -: 8] = PAD_BYTE;
            end
        end
        if (putlen_i) begin
            blk_o[63:0] = len_i;
        end
    end

endmodule

// File: rtl/sha256_stream_padder.sv
// Byte stream in, FIPS 180-4 padded 512-bit blocks out, with first/last
// flags for a chained SHA-256 core. Single 64-byte buffer.
module sha256_stream_padder
    import sha256_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    input  logic [7:0]              s_data,
    input  logic                    s_last,
    output logic                    s_ready,
    output logic                    blk_valid,
    output logic [SHA256_BLK_W-1:0] blk_data,
    output logic                    blk_first,
    output logic                    blk_last,
    input  logic                    blk_ready
);

    pad_state_e              state_q;
    logic [SHA256_BLK_W-1:0] blk_q;
    logic [SHA256_BLK_W-1:0] wr_blk;
    logic [SHA256_BLK_W-1:0] fill_out;
    logic [6:0]              pos_q;
    logic [6:0]              wr_pos;
    logic [6:0]              fill_pos;
    logic [LEN_W-1:0]        len_q;
    logic [LEN_W-1:0]        len_inc;
    logic [SHA256_LEN_W-1:0] fill_len;
    logic                    fill_80;
    logic                    fill_lenen;
    logic                    first_q;
    logic                    final_q;
    logic                    pad2_q;
    logic                    mark80_q;
    logic                    rdy_q;
    logic                    vld_q;
    logic                    acc;

    // rdy_q is only ever high in ACCUM
    assign acc     = rdy_q && s_valid;
    assign wr_pos  = pos_q + 7'd1;
    assign len_inc = len_q + LEN_W'(8);

    always_comb begin
        wr_blk = blk_q;
        for (int k = 0; k < 64; k++) begin
            if (pos_q == 7'(k)) begin
                wr_blk[511-8*k -: 8] = s_data;
            end
        end
    end

    always_comb begin
        fill_pos   = wr_pos;
        fill_80    = 1'b1;
        fill_lenen = (wr_pos <= 7'd55);
        fill_len   = SHA256_LEN_W'(len_inc);
        if (state_q == PAD2) begin
            fill_pos   = 7'd0;
            fill_80    = mark80_q;
            fill_lenen = 1'b1;
            fill_len   = SHA256_LEN_W'(len_q);
        end
    end

    sha256_pad_fill u_fill (
        .data_i   (wr_blk),
        .pos_i    (fill_pos),
        .len_i    (fill_len),
        .put80_i  (fill_80),
        .putlen_i (fill_lenen),
        .blk_o    (fill_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ACCUM;
            blk_q    <= '0;
            pos_q    <= '0;
            len_q    <= '0;
            first_q  <= 1'b1;
            final_q  <= 1'b0;
            pad2_q   <= 1'b0;
            mark80_q <= 1'b0;
            rdy_q    <= 1'b0;
            vld_q    <= 1'b0;
        end else begin
            unique case (state_q)
                ACCUM: begin
                    rdy_q <= 1'b1;
                    if (acc) begin
                        pos_q <= wr_pos;
                        len_q <= len_inc;
                        if (s_last) begin
                            blk_q    <= fill_out;
                            final_q  <= (wr_pos <= 7'd55);
                            pad2_q   <= (wr_pos > 7'd55);
                            mark80_q <= (wr_pos == 7'd64);
                        end else begin
                            blk_q <= wr_blk;
                        end
                        if (s_last || wr_pos == 7'd64) begin
                            state_q <= SEND;
                            rdy_q   <= 1'b0;
                            vld_q   <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (blk_ready) begin
                        vld_q   <= 1'b0;
                        first_q <= 1'b0;
                        if (final_q) begin
                            state_q <= ACCUM;
                            pos_q   <= '0;
                            len_q   <= '0;
                            final_q <= 1'b0;
                            first_q <= 1'b1;
                            rdy_q   <= 1'b1;
                        end else if (pad2_q) begin
                            state_q <= PAD2;
                        end else begin
                            state_q <= ACCUM;
                            pos_q   <= '0;
                            rdy_q   <= 1'b1;
                        end
                    end
                end
                PAD2: begin
                    blk_q    <= fill_out;
                    final_q  <= 1'b1;
                    pad2_q   <= 1'b0;
                    mark80_q <= 1'b0;
                    state_q  <= SEND;
                    vld_q    <= 1'b1;
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

    assign s_ready   = rdy_q;
    assign blk_valid = vld_q;
    assign blk_data  = blk_q;
    assign blk_first = vld_q & first_q;
    assign blk_last  = vld_q & final_q;

endmodule

// File: tb/tb_sha256_stream_padder.sv
// Bench for sha256_stream_padder: directed table, reset corner, random
// messages checked against a queue-based padding model.
module tb_sha256_stream_padder;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         s_valid;
    logic [7:0]   s_data;
    logic         s_last;
    logic         s_ready;
    logic         blk_valid;
    logic [511:0] blk_data;
    logic         blk_first;
    logic         blk_last;
    logic         blk_ready;

    sha256_stream_padder #(.LEN_W(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .blk_valid (blk_valid),
        .blk_data  (blk_data),
        .blk_first (blk_first),
        .blk_last  (blk_last),
        .blk_ready (blk_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        int           n;
        int           pat;
        int           stall;
        int           nblk;
        logic [511:0] last_blk;
    } vec_t;

    vec_t         vecs[5];
    int           passed = 0;
    int           total = 0;
    logic [7:0]   msg[$];
    logic [511:0] exp_q[$];
    logic [511:0] got_data[$];
    logic         got_first[$];
    logic         got_last[$];

    task automatic chk(input bit ok, input string name,
                       input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    // Reference padding: append 0x80, zeros to 56 mod 64, 64-bit bit count
    function automatic void model(input logic [7:0] m[$],
                                  output logic [511:0] blks[$]);
        logic [7:0]   q[$];
        logic [63:0]  bits;
        logic [511:0] w;
        q = m;
        q.push_back(8'h80);
        while (q.size() % 64 != 56) q.push_back(8'h00);
        bits = 64'(m.size()) * 64'd8;
        for (int i = 7; i >= 0; i--) q.push_back(bits[8*i +: 8]);
        blks.delete();
        for (int b = 0; b < q.size() / 64; b++) begin
            w = '0;
            for (int k = 0; k < 64; k++) w[511-8*k -: 8] = q[64*b+k];
            blks.push_back(w);
        end
    endfunction

    task automatic run_msg(input logic [7:0] m[$], input int stall,
                           input bit rnd, input string name);
        int           idx = 0;
        int           cyc = 0;
        int           scnt = 0;
        int           serr = 0;
        bit           rdy_seen = 0;
        bit           done = 0;
        bit           accepted;
        logic [511:0] held = '0;
        got_data.delete();
        got_first.delete();
        got_last.delete();
        while (cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (done) break;
            accepted = s_valid && rdy_seen;
            if (accepted) idx++;
            if (blk_valid) begin
                if (s_ready) serr++;
                if (scnt == 0) held = blk_data;
                else if (blk_data !== held) serr++;
                if (scnt < stall) begin
                    blk_ready = 1'b0;
                    scnt++;
                end else begin
                    blk_ready = 1'b1;
                    got_data.push_back(blk_data);
                    got_first.push_back(blk_first);
                    got_last.push_back(blk_last);
                    scnt = 0;
                    if (blk_last) done = 1;
                end
            end else begin
                blk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
                scnt = 0;
            end
            if (idx < m.size()) begin
                if (!s_valid || accepted)
                    s_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                s_data = m[idx];
                s_last = (idx == m.size() - 1);
            end else begin
                s_valid = 1'b0;
                s_last  = 1'b0;
            end
            rdy_seen = s_ready;
        end
        blk_ready = 1'b0;
        s_valid   = 1'b0;
        s_last    = 1'b0;
        chk(done, {name, " timeout"}, 512'(cyc), 512'(0));
        chk(serr == 0, {name, " stall hold"}, 512'(serr), 512'(0));
    endtask

    task automatic compare_model(input string name);
        int n;
        bit ok;
        model(msg, exp_q);
        chk(got_data.size() == exp_q.size(), {name, " block count"},
            512'(got_data.size()), 512'(exp_q.size()));
        n = (got_data.size() < exp_q.size()) ? got_data.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            ok = (got_data[i] === exp_q[i]) && (got_first[i] == (i == 0))
                 && (got_last[i] == (i == exp_q.size() - 1));
            chk(ok, $sformatf("%s blk%0d", name, i), got_data[i], exp_q[i]);
        end
    endtask

    task automatic reset_check(input string name);
        chk(s_ready == 1'b0, {name, " s_ready"}, 512'(s_ready), 512'(0));
        chk(blk_valid == 1'b0, {name, " blk_valid"}, 512'(blk_valid), 512'(0));
        chk(blk_data == '0, {name, " blk_data"}, blk_data, 512'(0));
        chk({blk_first, blk_last} == 2'b00, {name, " flags"},
            512'({blk_first, blk_last}), 512'(0));
    endtask

    task automatic build(input int n, input int pat);
        msg.delete();
        for (int i = 0; i < n; i++) begin
            case (pat)
                0:       msg.push_back(8'h00);
                1:       msg.push_back(8'(i));
                2:       msg.push_back(8'(8'h61 + i));
                default: msg.push_back(8'($urandom_range(0, 255)));
            endcase
        end
    endtask

    task automatic run_vec(input vec_t v);
        build(v.n, v.pat);
        run_msg(msg, v.stall, 1'b0, v.name);
        compare_model(v.name);
        chk(got_data.size() == v.nblk, {v.name, " table count"},
            512'(got_data.size()), 512'(v.nblk));
        if (got_data.size() > 0)
            chk(got_data[got_data.size()-1] === v.last_blk,
                {v.name, " table last"}, got_data[got_data.size()-1], v.last_blk);
        else
            chk(1'b0, {v.name, " table last"}, 512'(0), v.last_blk);
    endtask

    initial begin
        vecs[0] = '{"abc", 3, 2, 0, 1, {32'h61626380, 416'h0, 64'h18}};
        vecs[1] = '{"z55", 55, 0, 0, 1, {440'h0, 8'h80, 64'h1B8}};
        vecs[2] = '{"z56", 56, 0, 0, 2, {448'h0, 64'h1C0}};
        vecs[3] = '{"inc64", 64, 1, 0, 2, {8'h80, 440'h0, 64'h200}};
        vecs[4] = '{"k1024", 1024, 1, 10, 17, {8'h80, 440'h0, 64'h2000}};

        rst_n     = 1'b0;
        s_valid   = 1'b0;
        s_data    = 8'h00;
        s_last    = 1'b0;
        blk_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset_check("reset");
        rst_n = 1'b1;

        for (int v = 0; v < 5; v++) run_vec(vecs[v]);

        build(56, 0);
        run_msg(msg, 0, 1'b0, "z56 first");
        chk(got_data.size() > 0 && got_data[0] === {448'h0, 8'h80, 56'h0},
            "z56 blk0 const", got_data.size() > 0 ? got_data[0] : '0,
            {448'h0, 8'h80, 56'h0});

        // Abandon a message mid-stream with reset, then send "abc"
        @(negedge clk);
        for (int i = 0; i < 30; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(8'hA0 + i);
            s_last  = 1'b0;
            @(negedge clk);
        end
        s_valid = 1'b0;
        rst_n   = 1'b0;
        #1;
        reset_check("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(vecs[0]);
        chk(got_first.size() == 1 && got_first[0] == 1'b1, "midreset first",
            512'(got_first.size() > 0 ? got_first[0] : 1'b0), 512'(1));

        for (int r = 0; r < 20; r++) begin
            build($urandom_range(1, 200), 3);
            run_msg(msg, $urandom_range(0, 3), 1'b1, $sformatf("rnd%0d", r));
            compare_model($sformatf("rnd%0d", r));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
